// File: rtl/carrd_wb_arbiter_pkg.sv
// Shared types and constants for the vector writeback arbiter.
// Also holds the per-unit lane normalization applied when a result is captured.
package carrd_wb_pkg;

  localparam int NUM_UNITS = 5;
  localparam int LANE_W    = 128;
  localparam int LANES     = 4;
  localparam int DATA_W    = LANES * LANE_W;
  localparam int ADDR_W    = 5;
  localparam int UNIT_W    = 3;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU  = 3'd0,
    UNIT_MUL  = 3'd1,
    UNIT_LSU  = 3'd2,
    UNIT_SLDU = 3'd3,
    UNIT_RED  = 3'd4
  } unit_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_V    = 2'd1;
  localparam logic [1:0] SEL_X    = 2'd2;

  // LSU broadcasts its 32-bit word to every lane; RED produces a single scalar in lane0.
  function automatic logic [DATA_W-1:0] normalize_lanes(input unit_e unit,
                                                        input logic [DATA_W-1:0] raw);
    logic [LANE_W-1:0] word;
    word = {{(LANE_W-32){1'b0}}, raw[31:0]};
    case (unit)
      UNIT_LSU: normalize_lanes = {LANES{word}};
      UNIT_RED: normalize_lanes = {{(DATA_W-LANE_W){1'b0}}, word};
      default:  normalize_lanes = raw;
    endcase
  endfunction

endpackage

// File: rtl/carrd_wb_arbiter_if.sv
// Unit-side handshake and register-file write bus of the writeback arbiter.
// The arbiter uses the slave modport; the unit/RF environment uses master.
interface carrd_wb_arbiter_if;
  import carrd_wb_pkg::*;

  logic                                flush;
  logic [NUM_UNITS-1:0]                done;
  logic [NUM_UNITS-1:0]                ready;
  logic [NUM_UNITS-1:0][DATA_W-1:0]    result;
  logic [NUM_UNITS-1:0][1:0]           sel_dest;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]    dest_addr;
  logic                                v_reg_wr_en;
  logic                                x_reg_wr_en;
  logic [ADDR_W-1:0]                   wr_addr;
  logic [LANE_W-1:0]                   reg_wr_data;
  logic [LANE_W-1:0]                   reg_wr_data_2;
  logic [LANE_W-1:0]                   reg_wr_data_3;
  logic [LANE_W-1:0]                   reg_wr_data_4;
  logic                                retire_valid;
  logic [UNIT_W-1:0]                   retire_unit;
  logic                                idle;

  modport slave (
    input  flush, done, result, sel_dest, dest_addr,
    output ready, v_reg_wr_en, x_reg_wr_en, wr_addr,
           reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
           retire_valid, retire_unit, idle
  );

  modport master (
    output flush, done, result, sel_dest, dest_addr,
    input  ready, v_reg_wr_en, x_reg_wr_en, wr_addr,
           reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
           retire_valid, retire_unit, idle
  );

endinterface

// File: rtl/carrd_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus index, pointer advances past the winner.
// Generic so it can be reused for other shared ports.
module carrd_rr_arbiter #(
  parameter int N = 5
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [N-1:0]                          req,
  output logic [N-1:0]                          grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
  output logic                                  grant_valid
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_reg) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      ptr_next = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/carrd_wb_arbiter.sv
// Writeback arbiter: one holding slot per functional unit, round-robin drain into
// a single registered register-file write port.
module carrd_wb_arbiter
  import carrd_wb_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  carrd_wb_arbiter_if.slave  wb
);

  logic [NUM_UNITS-1:0] valid_vec;
  logic [NUM_UNITS-1:0] ready_vec;
  logic [NUM_UNITS-1:0] capture;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant;
  logic [UNIT_W-1:0]    grant_idx;
  logic                 grant_valid;

  logic                 slot_valid_reg [NUM_UNITS];
  logic [DATA_W-1:0]    slot_data_reg  [NUM_UNITS];
  logic [1:0]           slot_sel_reg   [NUM_UNITS];
  logic [ADDR_W-1:0]    slot_addr_reg  [NUM_UNITS];

  logic                 v_wr_en_reg;
  logic                 x_wr_en_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;
  logic [DATA_W-1:0]    wr_data_reg;
  logic                 retire_valid_reg;
  logic [UNIT_W-1:0]    retire_unit_reg;

  // Masking requests during flush suppresses the grant, so the pointer holds.
  assign req = wb.flush ? '0 : valid_vec;

  carrd_rr_arbiter #(
    .N (NUM_UNITS)
  ) u_rr (
    .clk         (clk),
    .nrst        (nrst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
      assign valid_vec[gi] = slot_valid_reg[gi];
      // A slot being drained this cycle can take the unit's next result.
      assign ready_vec[gi] = !slot_valid_reg[gi] || grant[gi];
      assign capture[gi]   = wb.done[gi] && ready_vec[gi] && !wb.flush;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          slot_valid_reg[gi] <= 1'b0;
        end else if (wb.flush) begin
          slot_valid_reg[gi] <= 1'b0;
        end else if (capture[gi]) begin
          slot_valid_reg[gi] <= 1'b1;
        end else if (grant[gi]) begin
          slot_valid_reg[gi] <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (capture[gi]) begin
          slot_data_reg[gi] <= normalize_lanes(unit_e'(UNIT_W'(gi)), wb.result[gi]);
          slot_sel_reg[gi]  <= wb.sel_dest[gi];
          slot_addr_reg[gi] <= wb.dest_addr[gi];
        end
      end
    end
  endgenerate

  // Data and address hold between grants; only the strobes drop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v_wr_en_reg      <= 1'b0;
      x_wr_en_reg      <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      retire_valid_reg <= 1'b0;
      retire_unit_reg  <= '0;
    end else begin
      v_wr_en_reg      <= 1'b0;
      x_wr_en_reg      <= 1'b0;
      retire_valid_reg <= 1'b0;
      if (grant_valid) begin
        v_wr_en_reg      <= (slot_sel_reg[grant_idx] == SEL_V);
        x_wr_en_reg      <= (slot_sel_reg[grant_idx] == SEL_X);
        wr_addr_reg      <= slot_addr_reg[grant_idx];
        wr_data_reg      <= slot_data_reg[grant_idx];
        retire_valid_reg <= 1'b1;
        retire_unit_reg  <= grant_idx;
      end
    end
  end

  assign wb.ready         = ready_vec;
  assign wb.idle          = ~|valid_vec;
  assign wb.v_reg_wr_en   = v_wr_en_reg;
  assign wb.x_reg_wr_en   = x_wr_en_reg;
  assign wb.wr_addr       = wr_addr_reg;
  assign wb.reg_wr_data   = wr_data_reg[0*LANE_W +: LANE_W];
  assign wb.reg_wr_data_2 = wr_data_reg[1*LANE_W +: LANE_W];
  assign wb.reg_wr_data_3 = wr_data_reg[2*LANE_W +: LANE_W];
  assign wb.reg_wr_data_4 = wr_data_reg[3*LANE_W +: LANE_W];
  assign wb.retire_valid  = retire_valid_reg;
  assign wb.retire_unit   = retire_unit_reg;

endmodule
